// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, MIPS opcode/funct constants and decoded bundle
package alu_pkg;

  // ALU function code: bit0 unsigned, bit1 subtract, bit2 logic unit, bit3 compare
  localparam logic [3:0] AF_ADD  = 4'b0000;
  localparam logic [3:0] AF_ADDU = 4'b0001;
  localparam logic [3:0] AF_SUB  = 4'b0010;
  localparam logic [3:0] AF_SUBU = 4'b0011;
  localparam logic [3:0] AF_AND  = 4'b0100;
  localparam logic [3:0] AF_OR   = 4'b0101;
  localparam logic [3:0] AF_XOR  = 4'b0110;
  localparam logic [3:0] AF_NOR  = 4'b0111;
  localparam logic [3:0] AF_LUI  = 4'b0111;  // same code as nor; the i flag tells them apart
  localparam logic [3:0] AF_SLT  = 4'b1010;
  localparam logic [3:0] AF_SLTU = 4'b1011;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Decoded control bundle carried alongside the operands
  typedef struct packed {
    logic [3:0] af;
    logic       i;
    logic [4:0] dest;
    logic       wr_en;
    logic       trap_ovf;
    logic       illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational MIPS ALU instruction decode and operand select
module alu_decode
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [31:0]  instr,
  input  logic [N-1:0] rs_val,
  input  logic [N-1:0] rt_val,
  output alu_ctrl_t    ctrl,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b
);

  logic [5:0]         opcode;
  logic [4:0]         rt_f;
  logic [4:0]         rd_f;
  logic [4:0]         shamt;
  logic [5:0]         funct;
  logic [15:0]        imm;
  logic signed [15:0] imm_s;
  logic [N-1:0]       imm_sext;
  logic [N-1:0]       imm_zext;
  logic               unused_rs_field;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign imm_s  = instr[15:0];

  // rs is addressed by the register file upstream; only its value reaches us
  assign unused_rs_field = ^instr[25:21];

  // Size casts extend to N bits without a zero-width replication when N == 16
  assign imm_sext = N'(imm_s);
  assign imm_zext = N'(imm);

  logic       legal;
  logic       is_imm;
  logic       sext;
  logic       ovf;
  logic [3:0] af_d;

  // Classify the instruction and pick function code, extension and trap behaviour
  always_comb begin
    legal  = 1'b0;
    is_imm = 1'b0;
    sext   = 1'b0;
    ovf    = 1'b0;
    af_d   = AF_ADD;
    if (opcode == OP_RTYPE) begin
      if (shamt == 5'd0) begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  begin af_d = AF_ADD; ovf = 1'b1; end
          FN_ADDU: af_d = AF_ADDU;
          FN_SUB:  begin af_d = AF_SUB; ovf = 1'b1; end
          FN_SUBU: af_d = AF_SUBU;
          FN_AND:  af_d = AF_AND;
          FN_OR:   af_d = AF_OR;
          FN_XOR:  af_d = AF_XOR;
          FN_NOR:  af_d = AF_NOR;
          FN_SLT:  af_d = AF_SLT;
          FN_SLTU: af_d = AF_SLTU;
          default: legal = 1'b0;
        endcase
      end
    end else begin
      legal  = 1'b1;
      is_imm = 1'b1;
      case (opcode)
        OP_ADDI:  begin af_d = AF_ADD; sext = 1'b1; ovf = 1'b1; end
        OP_ADDIU: begin af_d = AF_ADDU; sext = 1'b1; end
        OP_SLTI:  begin af_d = AF_SLT; sext = 1'b1; end
        OP_SLTIU: begin af_d = AF_SLTU; sext = 1'b1; end
        OP_ANDI:  af_d = AF_AND;
        OP_ORI:   af_d = AF_OR;
        OP_XORI:  af_d = AF_XOR;
        OP_LUI:   af_d = AF_LUI;
        default:  legal = 1'b0;
      endcase
    end
  end

  // Assemble the bundle and operands; illegal encodings collapse to all-zero fields
  always_comb begin
    ctrl = '0;
    op_a = '0;
    op_b = '0;
    if (legal) begin
      ctrl.af       = af_d;
      ctrl.i        = is_imm;
      ctrl.dest     = is_imm ? rt_f : rd_f;
      ctrl.wr_en    = (ctrl.dest != 5'd0);
      ctrl.trap_ovf = ovf;
      op_a          = rs_val;
      if (is_imm) op_b = sext ? imm_sext : imm_zext;
      else        op_b = rt_val;
    end else begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - registered ALU issue stage with valid/ready handshake and sequence tags
module alu_issue
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int TAGW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [N-1:0]    rs_val,
  input  logic [N-1:0]    rt_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            ex_ready,
  output logic [N-1:0]    a,
  output logic [N-1:0]    b,
  output logic [3:0]      af,
  output logic            i,
  output logic [4:0]      dest,
  output logic            wr_en,
  output logic            trap_ovf,
  output logic            illegal,
  output logic [TAGW-1:0] tag
);

  alu_ctrl_t     dec_ctrl;
  logic [N-1:0]  dec_a;
  logic [N-1:0]  dec_b;

  alu_decode #(.N(N)) u_decode (
    .instr  (instr),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .ctrl   (dec_ctrl),
    .op_a   (dec_a),
    .op_b   (dec_b)
  );

  alu_ctrl_t       ctrl_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            valid_q;
  logic [TAGW-1:0] tag_q;
  logic [TAGW-1:0] tag_cnt;
  logic            accept;

  // Ready depends only on the slot being free or draining, never on in_valid
  assign in_ready = !rst && !flush && (!valid_q || ex_ready);
  assign accept   = in_valid && in_ready;

  // Pipeline register: flush beats accept, and a consume without accept empties the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      tag_cnt <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      a_q     <= dec_a;
      b_q     <= dec_b;
      tag_q   <= tag_cnt;
      tag_cnt <= tag_cnt + 1'b1;
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign af        = ctrl_q.af;
  assign i         = ctrl_q.i;
  assign dest      = ctrl_q.dest;
  assign wr_en     = ctrl_q.wr_en;
  assign trap_ovf  = ctrl_q.trap_ovf;
  assign illegal   = ctrl_q.illegal;
  assign tag       = tag_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue
module tb_alu_issue;

  localparam int N    = 32;
  localparam int TAGW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [N-1:0]    rs_val;
  logic [N-1:0]    rt_val;
  logic            flush;
  logic            out_valid;
  logic            ex_ready;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic [3:0]      af;
  logic            i;
  logic [4:0]      dest;
  logic            wr_en;
  logic            trap_ovf;
  logic            illegal;
  logic [TAGW-1:0] tag;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue #(.N(N), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .out_valid (out_valid),
    .ex_ready  (ex_ready),
    .a         (a),
    .b         (b),
    .af        (af),
    .i         (i),
    .dest      (dest),
    .wr_en     (wr_en),
    .trap_ovf  (trap_ovf),
    .illegal   (illegal),
    .tag       (tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; rs_val = '0; rt_val = '0;
    flush = 1'b0; ex_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_a", a, 0);
    check("rst_af", af, 0);
    check("rst_tag", tag, 0);
    rst = 1'b0; #1;
    check("post_rst_in_ready", in_ready, 1);

    // add $8,$9,$10
    in_valid = 1'b1; instr = 32'h012A4020; rs_val = 5; rt_val = 7;
    tick();
    check("add_valid", out_valid, 1);
    check("add_af", af, 4'b0000);
    check("add_i", i, 0);
    check("add_a", a, 5);
    check("add_b", b, 7);
    check("add_dest", dest, 8);
    check("add_wr_en", wr_en, 1);
    check("add_trap", trap_ovf, 1);
    check("add_tag", tag, 0);
    check("add_illegal", illegal, 0);

    // andi: zero-extended immediate
    instr = itype(6'h0C, 5'd1, 5'd3, 16'h8000); rs_val = 32'h1234;
    tick();
    check("andi_b", b, 32'h00008000);
    check("andi_af", af, 4'b0100);
    check("andi_i", i, 1);
    check("andi_dest", dest, 3);
    check("andi_a", a, 32'h1234);
    check("andi_trap", trap_ovf, 0);
    check("andi_tag", tag, 1);

    // slti: sign-extended immediate
    instr = itype(6'h0A, 5'd1, 5'd4, 16'h8000);
    tick();
    check("slti_b", b, 32'hFFFF8000);
    check("slti_af", af, 4'b1010);
    check("slti_tag", tag, 2);

    // lui
    instr = itype(6'h0F, 5'd0, 5'd5, 16'h1234);
    tick();
    check("lui_af", af, 4'b0111);
    check("lui_i", i, 1);
    check("lui_trap", trap_ovf, 0);
    check("lui_b", b, 32'h00001234);
    check("lui_tag", tag, 3);

    // stall three cycles with a sub waiting upstream
    instr = rtype(5'd2, 5'd3, 5'd4, 6'h22); rs_val = 20; rt_val = 3; ex_ready = 1'b0;
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_af", af, 4'b0111);
      check("stall_b", b, 32'h00001234);
      check("stall_tag", tag, 3);
      check("stall_in_ready_hold", in_ready, 0);
    end
    ex_ready = 1'b1; #1;
    check("release_in_ready", in_ready, 1);
    tick();
    check("sub_af", af, 4'b0010);
    check("sub_a", a, 20);
    check("sub_b", b, 3);
    check("sub_trap", trap_ovf, 1);
    check("sub_tag", tag, 4);

    // flush together with a valid offer
    instr = rtype(5'd1, 5'd2, 5'd6, 6'h21); flush = 1'b1; #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_af_held", af, 4'b0010);
    flush = 1'b0;
    tick();
    check("post_flush_af", af, 4'b0001);
    check("post_flush_tag", tag, 5);

    // reset while stalled drops the held op
    in_valid = 1'b0; ex_ready = 1'b0;
    tick();
    check("hold_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    check("midstall_rst_valid", out_valid, 0);
    check("midstall_rst_tag", tag, 0);
    rst = 1'b0; ex_ready = 1'b1;

    // nine back-to-back accepts: tags wrap after 7
    in_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      instr = rtype(5'd1, 5'd2, 5'(k + 1), 6'h24);
      tick();
      check("b2b_valid", out_valid, 1);
      check("b2b_dest", dest, k + 1);
      check("b2b_tag", tag, k % 8);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);

    // illegal: funct mult
    in_valid = 1'b1; instr = 32'h00000018; rs_val = 32'hDEAD; rt_val = 32'hBEEF;
    tick();
    check("mult_valid", out_valid, 1);
    check("mult_illegal", illegal, 1);
    check("mult_wr_en", wr_en, 0);
    check("mult_af", af, 4'b0000);
    check("mult_a", a, 0);
    check("mult_b", b, 0);
    check("mult_tag", tag, 1);

    // add with nonzero shamt is illegal
    instr = 32'h012A4060;
    tick();
    check("shamt_illegal", illegal, 1);
    check("shamt_dest", dest, 0);
    check("shamt_trap", trap_ovf, 0);

    // add to $0: legal but no write-back
    instr = 32'h012A0020;
    tick();
    check("rd0_illegal", illegal, 0);
    check("rd0_wr_en", wr_en, 0);
    check("rd0_trap", trap_ovf, 1);
    check("rd0_a", a, 32'hDEAD);

    in_valid = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
